// File: rtl/seq_fact_unit.sv
// Sequential factorial engine: one truncated multiply per clock, sticky overflow.
// Handshake: start accepted while ready; done pulses once with dout/ovf valid.
module seq_fact_unit #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  din,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] dout,
  output logic             ovf
);

  localparam int PW = OUT_W + IN_W;
  localparam logic [IN_W-1:0]  CNT_ONE = IN_W'(1);
  localparam logic [OUT_W-1:0] ACC_ONE = OUT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [IN_W-1:0]  cnt_q, cnt_d;
  logic             ovf_r_q, ovf_r_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;

  logic [PW-1:0]    prod;
  logic             prod_hi;

  // Full-width product so bits lost to truncation can still raise the overflow flag.
  assign prod    = {{IN_W{1'b0}}, acc_q} * {{OUT_W{1'b0}}, cnt_q};
  assign prod_hi = |prod[PW-1:OUT_W];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_r_d = ovf_r_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = ACC_ONE;
          cnt_d   = din;
          ovf_r_d = 1'b0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_q <= CNT_ONE) begin
          dout_d  = acc_q;
          ovf_d   = ovf_r_q;
          state_d = S_DONE;
        end else begin
          acc_d   = prod[OUT_W-1:0];
          cnt_d   = cnt_q - CNT_ONE;
          ovf_r_d = ovf_r_q | prod_hi;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_r_q <= 1'b0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_r_q <= ovf_r_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_CALC) || (state_q == S_DONE);
  assign done  = (state_q == S_DONE);
  assign dout  = dout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_seq_fact_unit.sv
// Directed bench for seq_fact_unit at OUT_W=64 and OUT_W=16 with a result scoreboard.
module tb_seq_fact_unit;

  typedef struct {
    logic [63:0] d;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start64, start16;
  logic [7:0]  din;
  logic        rdy64, busy64, done64, ovf64;
  logic [63:0] dout64;
  logic        rdy16, busy16, done16, ovf16;
  logic [15:0] dout16;

  int checks = 0;
  int errors = 0;
  int done_cnt64 = 0;
  int done_cnt16 = 0;
  logic prev_done64 = 1'b0;
  logic prev_done16 = 1'b0;
  exp_t q64[$];
  exp_t q16[$];

  always #5 clk = ~clk;

  seq_fact_unit #(.IN_W(8), .OUT_W(64)) u64 (
    .clk(clk), .rst(rst), .start(start64), .din(din),
    .ready(rdy64), .busy(busy64), .done(done64), .dout(dout64), .ovf(ovf64)
  );

  seq_fact_unit #(.IN_W(8), .OUT_W(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .din(din),
    .ready(rdy16), .busy(busy16), .done(done16), .dout(dout16), .ovf(ovf16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Exact n! at wide precision, then reduced to the result width.
  function automatic exp_t fact_model(input int n, input int w);
    logic [127:0] p;
    exp_t e;
    p = 128'd1;
    for (int i = 2; i <= n; i++) p = p * 128'(i);
    e.o = ((p >> w) != 128'd0);
    e.d = 64'(p & ((128'd1 << w) - 128'd1));
    return e;
  endfunction

  always @(negedge clk) begin
    if (done64) begin
      done_cnt64++;
      chk("done64_single", {63'd0, prev_done64}, 64'd0);
      if (q64.size() == 0) chk("done64_unexpected", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q64.pop_front();
        chk("dout64", dout64, e.d);
        chk("ovf64", {63'd0, ovf64}, {63'd0, e.o});
      end
    end
    prev_done64 = done64;
  end

  always @(negedge clk) begin
    if (done16) begin
      done_cnt16++;
      chk("done16_single", {63'd0, prev_done16}, 64'd0);
      if (q16.size() == 0) chk("done16_unexpected", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q16.pop_front();
        chk("dout16", {48'd0, dout16}, {48'd0, e.d[15:0]});
        chk("ovf16", {63'd0, ovf16}, {63'd0, e.o});
      end
    end
    prev_done16 = done16;
  end

  // Called right after an accept edge; counts negedges until done.
  task automatic wait_done(input bit nar, input int n);
    int lat;
    logic dn;
    int want;
    lat  = 0;
    want = ((n > 1) ? n : 1) + 1;
    do begin
      @(negedge clk);
      lat++;
      dn = nar ? done16 : done64;
      if (lat == 1) begin
        chk("ready_after_accept", {63'd0, nar ? rdy16 : rdy64}, 64'd0);
        chk("busy_after_accept", {63'd0, nar ? busy16 : busy64}, 64'd1);
      end
    end while (!dn && lat < 300);
    chk($sformatf("latency_n%0d", n), 64'(lat), 64'(want));
  endtask

  task automatic run_job(input int n, input bit nar);
    @(negedge clk);
    chk("ready_before_start", {63'd0, nar ? rdy16 : rdy64}, 64'd1);
    din = 8'(n);
    if (nar) begin
      start16 = 1'b1;
      q16.push_back(fact_model(n, 16));
    end else begin
      start64 = 1'b1;
      q64.push_back(fact_model(n, 64));
    end
    @(posedge clk);
    #1;
    start64 = 1'b0;
    start16 = 1'b0;
    wait_done(nar, n);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start64 = 1'b0; start16 = 1'b0; din = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, rdy64}, 64'd1);
    chk("rst_busy", {63'd0, busy64}, 64'd0);
    chk("rst_done", {63'd0, done64}, 64'd0);
    chk("rst_dout", dout64, 64'd0);
    chk("rst_ovf", {63'd0, ovf64}, 64'd0);
    chk("rst_dout16", {48'd0, dout16}, 64'd0);

    run_job(5, 1'b0);
    repeat (3) @(negedge clk);
    chk("dout_hold", dout64, 64'd120);
    run_job(4, 1'b0);
    run_job(0, 1'b0);
    run_job(1, 1'b0);
    run_job(20, 1'b0);
    chk("fact20_const", dout64, 64'd2432902008176640000);
    run_job(21, 1'b0);
    chk("fact21_const", dout64, 64'd14197454024290336768);
    chk("fact21_ovf", {63'd0, ovf64}, 64'd1);

    run_job(8, 1'b1);
    run_job(9, 1'b1);
    chk("fact9_w16_const", {48'd0, dout16}, 64'd35200);
    run_job(3, 1'b1);
    chk("sticky_cleared", {63'd0, ovf16}, 64'd0);

    // start held high: second job must take din from its own accept edge.
    @(negedge clk);
    chk("abuse_ready", {63'd0, rdy64}, 64'd1);
    start64 = 1'b1;
    din = 8'd6;
    q64.push_back(fact_model(6, 64));
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("abuse_done_k%0d", k), {63'd0, done64}, {63'd0, k == 7});
      chk($sformatf("abuse_ready_k%0d", k), {63'd0, rdy64}, {63'd0, k == 8});
      din = (k % 2 == 1) ? 8'd6 : 8'd7;
    end
    q64.push_back(fact_model(7, 64));
    @(posedge clk);
    #1 start64 = 1'b0;
    wait_done(1'b0, 7);
    chk("abuse_second", dout64, 64'd5040);

    // Reset in the middle of a long job: no result may appear.
    @(negedge clk);
    din = 8'd10;
    start64 = 1'b1;
    @(posedge clk);
    #1 start64 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    d0 = done_cnt64;
    @(negedge clk);
    chk("midrst_ready", {63'd0, rdy64}, 64'd1);
    chk("midrst_busy", {63'd0, busy64}, 64'd0);
    chk("midrst_done", {63'd0, done64}, 64'd0);
    chk("midrst_dout", dout64, 64'd0);
    chk("midrst_ovf", {63'd0, ovf64}, 64'd0);
    repeat (15) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt64 - d0), 64'd0);

    // rst and start on the same edge: request dropped.
    @(negedge clk);
    rst = 1'b1;
    start64 = 1'b1;
    din = 8'd5;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start64 = 1'b0;
    d0 = done_cnt64;
    @(negedge clk);
    chk("rststart_ready", {63'd0, rdy64}, 64'd1);
    chk("rststart_busy", {63'd0, busy64}, 64'd0);
    repeat (10) @(negedge clk);
    chk("rststart_no_done", 64'(done_cnt64 - d0), 64'd0);

    chk("q64_empty", 64'(q64.size()), 64'd0);
    chk("q16_empty", 64'(q16.size()), 64'd0);
    chk("done16_count", 64'(done_cnt16), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_fact_unit.md
# seq_fact_unit

Parametrised, multi-cycle factorial engine: computes n! for an IN_W-bit operand by iterative multiply-accumulate, one multiply per clock. It replaces single-expression recursive factorial evaluation with a bounded-area sequential datapath. It sits behind a simple start/ready/done handshake and is intended as the reusable arithmetic sub-block for functions that used combinational recursion. It adds result truncation to OUT_W and a sticky overflow flag.

## Interface
- IN_W, default 8: operand width; n ranges 0..2^IN_W-1.
- OUT_W, default 64: result width; must be ≥ 2.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- start  in  1  request; accepted only when ready=1.
- din  in  IN_W  operand n; sampled on the accept edge only.
- ready  out  1  high in IDLE; combinational decode of state.
- busy  out  1  high in CALC and DONE.
- done  out  1  one-cycle pulse; dout/ovf valid while high.
- dout  out  OUT_W  n! mod 2^OUT_W; holds until next completion.
- ovf  out  1  true n! ≥ 2^OUT_W; updated together with dout.

## Operation
- States: IDLE, CALC, DONE. Internal: acc (OUT_W), cnt (IN_W), ovf_r (sticky).
- IDLE: ready=1. start=1 at an edge → accept: acc←1, cnt←din, ovf_r←0, go CALC. start=0 → stay.
- CALC: if cnt ≤ 1 → dout←acc, ovf←ovf_r, go DONE. Else acc←low OUT_W bits of (acc × cnt), cnt←cnt−1; if full (OUT_W+IN_W)-bit product has any bit set above OUT_W−1, ovf_r←1.
- DONE: done=1 for this cycle only; unconditionally go IDLE.
- Arithmetic: product formed at full OUT_W+IN_W width, then truncated; truncated accumulation keeps dout exactly n! mod 2^OUT_W. Once ovf_r is set it stays set until the next accept.
- 0! = 1! = 1, ovf=0.
- start while busy=1 (CALC or DONE) is ignored; din changes while busy have no effect.
- rst: state←IDLE, acc←0, cnt←0, ovf_r←0, dout←0, ovf←0, done←0. Applies mid-computation; in-flight result is discarded, no done pulse.
- rst and start high on the same edge: rst wins, request dropped.

## Timing
- Reset values: ready=1, busy=0, done=0, dout=0, ovf=0.
- Accept edge = edge E where ready=1 and start=1. ready falls, busy rises, in the cycle after E.
- For n ≥ 2: n−1 multiply edges (E+1..E+n−1), terminate edge E+n, done high in cycle after E+n.
- For n ∈ {0,1}: terminate at E+1; done high in cycle after E+1.
- General latency: done high in the cycle following edge E+max(n,1); busy high for max(n,1)+1 cycles.
- dout/ovf change only on the terminate edge; stable otherwise.
- Earliest next accept: edge at end of the done cycle (ready=1 the cycle after done). Throughput: one result per max(n,1)+2 cycles with start held high.

## Test plan
- Reset: assert rst 2 cycles, then also mid-CALC (n=10, after 4 cycles) → ready=1, busy=0, done=0, dout=0, ovf=0; no done pulse for the aborted job.
- Basic, defaults: din=5, start 1 cycle → done exactly 5 cycles after accept edge, dout=120, ovf=0; then din=4 → dout=24; din=0 → dout=1 and din=1 → dout=1, each with done 1 cycle after accept.
- Max fit/overflow, OUT_W=64: din=20 → dout=2432902008176640000, ovf=0; din=21 → dout=14197454024290336768, ovf=1.
- Narrow result, OUT_W=16: din=8 → dout=40320, ovf=0; din=9 → dout=35200, ovf=1; following din=3 → dout=6, ovf=0 (sticky cleared on accept).
- Handshake abuse: hold start=1 continuously with din toggling 6/7 during CALC → only din latched at each accept used; results 720 then next accept value; no accept during busy; done always single-cycle.
- rst and start on same edge with din=5 → stays IDLE, no done within 10 cycles.
